run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller_pkg.sv | 14 +
 rtl/run_controller_key_debounce.sv | 67 ++++++
 rtl/run_controller.sv | 101 ++++++++++
 tb/tb_run_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_controller_pkg.sv
// Shared types for the run/step/breakpoint controller: FSM state encoding
// and the commit-counter width.
package run_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2,
    ST_BRK  = 2'd3
  } state_e;

  localparam int CYC_W = 32;

endpackage

// File: rtl/run_controller_key_debounce.sv
// One board button: 2-flop synchronizer, run-length debouncer and a one-cycle
// press pulse on each debounced 1->0 transition.
module key_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_p
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          arm_q, arm_d;
  logic          press_q, press_d;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    arm_d   = arm_q;
    // cnt tracks how many consecutive samples have equalled last_q
    if (sync2_q != last_q) begin
      last_d = sync2_q;
      cnt_d  = CW'(1);
    end else if (cnt_q != DB_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_d == DB_MAX) begin
      level_d = last_d;
      // a key held through reset only counts once it has been seen released
      if (last_d) arm_d = 1'b1;
    end
    press_d = level_q & ~level_d & arm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      arm_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      arm_q   <= arm_d;
      press_q <= press_d;
    end
  end

  assign press_p = press_q;

endmodule

// File: rtl/run_controller.sv
// Run/step/breakpoint controller for a board-level CPU: gates datapath
// commits from debounced buttons, a PC breakpoint and halt instructions.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int DB_CYCLES = 16,
  parameter int PC_W      = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       KEY,
  input  logic [PC_W-1:0]  PC,
  input  logic             BP_EN,
  input  logic [PC_W-1:0]  BP_ADDR,
  input  logic             HALT_REQ,
  output logic             CPU_EN,
  output logic [1:0]       STATE,
  output logic             BP_HIT,
  output logic [CYC_W-1:0] CYC_CNT
);

  logic stp_p, run_p;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_step (
    .clk     (CLK),
    .rst_n   (RST),
    .key_n   (KEY[0]),
    .press_p (stp_p)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_run (
    .clk     (CLK),
    .rst_n   (RST),
    .key_n   (KEY[1]),
    .press_p (run_p)
  );

  state_e            state_q, state_d;
  logic              skip_q, skip_d;
  logic              bp_hit_q, bp_hit_d;
  logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic              bp_match;
  logic              cpu_en;

  // skip lets the instruction at the breakpoint commit once after a resume
  assign bp_match = BP_EN && (PC == BP_ADDR) && !skip_q;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cpu_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run_p)      state_d = ST_RUN;
        else if (stp_p) state_d = ST_STEP;
      end
      ST_STEP: begin
        cpu_en  = !HALT_REQ;
        state_d = HALT_REQ ? ST_BRK : ST_IDLE;
      end
      ST_RUN: begin
        cpu_en = !HALT_REQ && !bp_match;
        skip_d = 1'b0;
        if (HALT_REQ || bp_match) state_d = ST_BRK;
        else if (run_p)           state_d = ST_IDLE;
      end
      ST_BRK: begin
        if (run_p) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (stp_p) begin
          state_d = ST_STEP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    bp_hit_d  = (state_d == ST_BRK);
    cyc_cnt_d = cyc_cnt_q;
    if (cpu_en) cyc_cnt_d = cyc_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      skip_q    <= 1'b0;
      bp_hit_q  <= 1'b0;
      cyc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      bp_hit_q  <= bp_hit_d;
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign CPU_EN  = cpu_en;
  assign STATE   = state_q;
  assign BP_HIT  = bp_hit_q;
  assign CYC_CNT = cyc_cnt_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a tiny datapath advances PC on each commit; the
// expected committed PCs are queued up front and a negedge monitor pops them.
module tb_run_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  key;
  logic [31:0] pc;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic        halt_req;
  logic        cpu_en;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] cyc_cnt;

  run_controller #(.DB_CYCLES(4), .PC_W(32)) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .KEY      (key),
    .PC       (pc),
    .BP_EN    (bp_en),
    .BP_ADDR  (bp_addr),
    .HALT_REQ (halt_req),
    .CPU_EN   (cpu_en),
    .STATE    (state),
    .BP_HIT   (bp_hit),
    .CYC_CNT  (cyc_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pcm;
  logic [31:0] model_cyc;
  logic        pc_load = 1'b0;
  logic [31:0] pc_val = '0;
  logic        track = 1'b0;
  logic        saw_step = 1'b0;
  logic [1:0]  first_state = 2'd0;

  // datapath stand-in: PC moves on every commit
  always @(posedge clk) begin
    if (pc_load)     pc <= pc_val;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && cpu_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit pc=%h (no commit expected)", pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (pc !== e) begin
          errors++;
          $display("FAIL commit_pc got=%h exp=%h", pc, e);
        end
      end
    end
    if (track) begin
      if (state == 2'd1) saw_step = 1'b1;
      if (first_state == 2'd0 && state != 2'd0) first_state = state;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic push_exp();
    exp_q.push_back(pcm);
    pcm       = pcm + 32'd4;
    model_cyc = model_cyc + 32'd1;
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_val  = v;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    pcm     = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    model_cyc = '0;
    wait_cycles(10);
  endtask

  task automatic press_key(input int idx, input int hold);
    key[idx] = 1'b0;
    wait_cycles(hold);
    key[idx] = 1'b1;
    tick();
  endtask

  task automatic bounce(input int idx, input int n);
    repeat (n) begin
      key[idx] = 1'b0;
      wait_cycles(2);
      key[idx] = 1'b1;
      wait_cycles(2);
    end
  endtask

  task automatic wait_pc(input logic [31:0] t);
    int n = 0;
    while (pc !== t && n < 100) begin
      tick();
      n++;
    end
    check("wait_pc_reached", pc, t);
  endtask

  task automatic check_brk(input string tag);
    check({tag, "_state"}, {30'd0, state}, 32'd3);
    check({tag, "_bp_hit"}, {31'd0, bp_hit}, 32'd1);
    check({tag, "_cyc_cnt"}, cyc_cnt, model_cyc);
    check({tag, "_queue_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; key = 2'b11; bp_en = 1'b0; bp_addr = '0; halt_req = 1'b0;
    pc = '0; pcm = '0; model_cyc = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    check("rst_cyc_cnt", cyc_cnt, 32'd0);
    check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);

    // step key held through reset release must not produce a press
    key[0] = 1'b0;
    load_pc(32'h0040_0000);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(20);
    key[0] = 1'b1;
    wait_cycles(10);
    check("held_rst_cyc_cnt", cyc_cnt, 32'd0);
    check("held_rst_state", {30'd0, state}, 32'd0);

    // single step from IDLE
    push_exp();
    press_key(0, 20);
    wait_cycles(10);
    check("step_cyc_cnt", cyc_cnt, 32'd1);
    check("step_state", {30'd0, state}, 32'd0);
    check("step_queue_drained", exp_q.size(), 32'd0);

    // bouncing run key, then breakpoint at 0x0040_0010
    do_reset();
    load_pc(32'h0040_0000);
    bp_en = 1'b1; bp_addr = 32'h0040_0010;
    repeat (4) push_exp();
    bounce(1, 3);
    press_key(1, 20);
    wait_cycles(10);
    check_brk("bp1");
    check("bp1_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("bp1_cyc_is_4", cyc_cnt, 32'd4);

    // resume: the breakpoint instruction commits once
    bp_addr = 32'h0040_0020;
    repeat (4) push_exp();
    press_key(1, 20);
    wait_cycles(10);
    check_brk("bp2");

    // halt instruction during RUN
    bp_en = 1'b0;
    repeat (4) push_exp();
    fork
      press_key(1, 20);
      begin
        wait_pc(32'h0040_0030);
        halt_req = 1'b1;
        #1;
        check("halt_cpu_en_same_cycle", {31'd0, cpu_en}, 32'd0);
      end
    join
    wait_cycles(5);
    check_brk("halt");
    press_key(0, 20);
    wait_cycles(10);
    check_brk("halt_step");
    halt_req = 1'b0;

    // both keys in the same cycle from IDLE
    do_reset();
    bp_en = 1'b1; bp_addr = pcm + 32'd8;
    repeat (2) push_exp();
    saw_step = 1'b0; first_state = 2'd0; track = 1'b1;
    key = 2'b00;
    wait_cycles(20);
    key = 2'b11;
    wait_cycles(10);
    track = 1'b0;
    check("both_no_step", {31'd0, saw_step}, 32'd0);
    check("both_first_state", {30'd0, first_state}, 32'd2);
    check_brk("both");

    // reset between clock edges while running
    bp_en = 1'b0;
    repeat (4) push_exp();
    fork
      press_key(1, 20);
      begin
        wait_pc(pcm);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("async_rst_state", {30'd0, state}, 32'd0);
        check("async_rst_cyc_cnt", cyc_cnt, 32'd0);
      end
    join
    wait_cycles(2);
    rst_n = 1'b1;
    model_cyc = '0;
    wait_cycles(10);

    // counter wrap
    force dut.cyc_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.cyc_cnt_q;
    tick();
    check("preload_cyc_cnt", cyc_cnt, 32'hFFFF_FFFF);
    model_cyc = 32'hFFFF_FFFF;
    push_exp();
    press_key(0, 20);
    wait_cycles(10);
    check("wrap_cyc_cnt", cyc_cnt, model_cyc);
    check("wrap_cyc_is_0", cyc_cnt, 32'd0);

    // randomized steps, runs to breakpoints and resumes
    do_reset();
    load_pc({$urandom_range(0, 32'h00FF_FFFF), 2'b00} & 32'h03FF_FFFC);
    bp_en = 1'b1;
    for (int it = 0; it < 8; it++) begin
      int n_steps;
      int k;
      n_steps = $urandom_range(1, 3);
      for (int s = 0; s < n_steps; s++) begin
        push_exp();
        bounce(0, $urandom_range(0, 3));
        press_key(0, $urandom_range(10, 20));
        wait_cycles($urandom_range(8, 14));
      end
      check("rnd_step_cyc_cnt", cyc_cnt, model_cyc);
      k = $urandom_range(1, 6);
      bp_addr = pcm + 32'(4 * k);
      repeat (k) push_exp();
      bounce(1, $urandom_range(0, 3));
      press_key(1, $urandom_range(12, 20));
      wait_cycles(10);
      check_brk("rnd_run");
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, 6);
        bp_addr = pcm + 32'(4 * k);
        repeat (k) push_exp();
        press_key(1, $urandom_range(12, 20));
        wait_cycles(10);
        check_brk("rnd_resume");
      end
    end

    check("final_queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
